// File: rtl/rpc19_server.sv
// RPC server stage: req/ack four-phase call interface executing ADD/MUL/ACC/READ against a persistent accumulator.
// Optional macro RPC19_CALLCOUNT_EN adds a 16-bit call_count output readable through READ with arg1=16'hFFFF.
module rpc19_server #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] arg0,
  input  logic [DATA_W-1:0] arg1,
  output logic              ack,
  output logic [DATA_W-1:0] result,
  output logic              err,
`ifdef RPC19_CALLCOUNT_EN
  output logic              busy,
  output logic [15:0]       call_count
`else
  output logic              busy
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

  localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_MUL  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_ACC  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_READ = CMD_W'(3);

  state_t            state;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] a_q;      // multiplicand, shifted left each MUL step
  logic [DATA_W-1:0] b_q;      // multiplier, shifted right each MUL step
  logic [DATA_W-1:0] prod;
  logic [CNT_W-1:0]  mul_cnt;
  logic [DATA_W-1:0] acc;

  logic [DATA_W-1:0] mul_sum;
  logic              exec_done;
  logic              exec_err;
  logic [DATA_W-1:0] exec_result;
  logic [DATA_W-1:0] exec_acc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mul_sum     = prod + (b_q[0] ? a_q : '0);
    exec_done   = 1'b1;
    exec_err    = 1'b0;
    exec_result = '0;
    exec_acc    = acc;
    case (cmd_q)
      CMD_ADD: exec_result = a_q + b_q;
      CMD_MUL: begin
        exec_done   = (mul_cnt == MUL_LAST);
        exec_result = mul_sum;
      end
      CMD_ACC: begin
        exec_acc    = acc + a_q;
        exec_result = exec_acc;
      end
      CMD_READ: begin
`ifdef RPC19_CALLCOUNT_EN
        if (b_q == DATA_W'(16'hFFFF)) begin
          exec_result = DATA_W'(call_count);
        end else begin
          exec_result = acc;
          exec_acc    = b_q;
        end
`else
        exec_result = acc;
        exec_acc    = b_q;
`endif
      end
      default: exec_err = 1'b1;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod    <= '0;
      mul_cnt <= '0;
      acc     <= '0;
      ack     <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
`ifdef RPC19_CALLCOUNT_EN
      call_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cmd_q   <= cmd;
            a_q     <= arg0;
            b_q     <= arg1;
            prod    <= '0;
            mul_cnt <= '0;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done) begin
            result <= exec_result;
            err    <= exec_err;
            acc    <= exec_acc;
            ack    <= 1'b1;
            state  <= RESP;
`ifdef RPC19_CALLCOUNT_EN
            call_count <= call_count + 16'd1;
`endif
          end else begin
            prod    <= mul_sum;
            a_q     <= a_q << 1;
            b_q     <= b_q >> 1;
            mul_cnt <= mul_cnt + 1'b1;
          end
        end
        RESP: begin
          // Result deliberately survives the return to IDLE.
          if (!req) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpc19_server.sv
// Directed self-checking bench for rpc19_server (DATA_W=32, CMD_W=2).
// Define RPC19_CALLCOUNT_EN for both files to exercise the call counter.
module tb_rpc19_server;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [31:0] arg0 = '0;
  logic [31:0] arg1 = '0;
  logic        ack;
  logic [31:0] result;
  logic        err;
  logic        busy;
`ifdef RPC19_CALLCOUNT_EN
  logic [15:0] call_count;
`endif

  int checks = 0;
  int errors = 0;

  rpc19_server #(.DATA_W(32), .CMD_W(2)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .req    (req),
    .cmd    (cmd),
    .arg0   (arg0),
    .arg1   (arg1),
    .ack    (ack),
    .result (result),
    .err    (err),
`ifdef RPC19_CALLCOUNT_EN
    .busy   (busy),
    .call_count (call_count)
`else
    .busy   (busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic start_call(input logic [1:0] c, input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk);
    req = 1'b1; cmd = c; arg0 = a0; arg1 = a1;
  endtask

  // Waits for ack; lat is the number of edges after the accepting edge.
  task automatic wait_ack(output int lat, output logic ok, output logic busy_all);
    ok = 1'b0; lat = -1; busy_all = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) busy_all = 1'b0;
      if (ack) begin ok = 1'b1; lat = i; break; end
    end
  endtask

  task automatic end_call;
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic call(input logic [1:0] c, input logic [31:0] a0, input logic [31:0] a1,
                      output logic [31:0] res, output logic e, output int lat);
    logic ok, ba;
    start_call(c, a0, a1);
    wait_ack(lat, ok, ba);
    res = result; e = err;
    checks++;
    if (!ok) begin errors++; $display("FAIL call_timeout: cmd %0d no ack within 100 cycles", c); end
    end_call();
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ack_release: ack=%b expected 0", ack); end
  endtask

  task automatic test_reset;
    logic [31:0] res; logic e; int lat;
    rst_n = 1'b0; req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, busy, err, result} !== 35'd0) begin
      errors++; $display("FAIL reset_hold: ack=%b busy=%b err=%b result=%h expected all 0", ack, busy, err, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack, busy, result} !== 34'd0) begin
      errors++; $display("FAIL reset_release: ack=%b busy=%b result=%h expected all 0", ack, busy, result);
    end
    call(2'd3, 32'd0, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'd0) begin errors++; $display("FAIL reset_read: got %h expected 0", res); end
  endtask

  task automatic test_add;
    logic [31:0] res; logic e; int lat;
    call(2'd0, 32'hFFFF_FFFF, 32'd2, res, e, lat);
    checks++;
    if (res !== 32'd1 || e !== 1'b0 || lat != 1) begin
      errors++; $display("FAIL add_wrap: result=%h err=%b lat=%0d expected 1/0/1", res, e, lat);
    end
    checks++;
    if (busy !== 1'b0 || result !== 32'd1) begin
      errors++; $display("FAIL add_idle: busy=%b result=%h expected 0/1", busy, result);
    end
  endtask

  task automatic test_mul;
    logic [31:0] res; logic e; int lat; logic ok, ba;
    start_call(2'd1, 32'd1234, 32'd5678);
    wait_ack(lat, ok, ba);
    checks++;
    if (!ok || lat != 32 || !ba || result !== 32'd7006652 || err !== 1'b0) begin
      errors++; $display("FAIL mul_basic: ok=%b lat=%0d busy_all=%b result=%0d expected 1/32/1/7006652", ok, lat, ba, result);
    end
    end_call();
    call(2'd1, 32'h0001_0000, 32'h0001_0000, res, e, lat);
    checks++;
    if (res !== 32'd0 || lat != 32) begin errors++; $display("FAIL mul_overflow: result=%h lat=%0d expected 0/32", res, lat); end
    // Operands changed while busy must be ignored.
    start_call(2'd1, 32'd3, 32'd5);
    @(negedge clk);
    cmd = 2'd0; arg0 = 32'd100; arg1 = 32'd200;
    wait_ack(lat, ok, ba);
    checks++;
    if (!ok || result !== 32'd15) begin errors++; $display("FAIL mul_hold_args: ok=%b result=%0d expected 1/15", ok, result); end
    end_call();
  endtask

  task automatic test_acc;
    logic [31:0] res; logic e; int lat;
    call(2'd2, 32'd10, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'd10 || lat != 1) begin errors++; $display("FAIL acc_first: result=%0d lat=%0d expected 10/1", res, lat); end
    call(2'd2, 32'd20, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'd30) begin errors++; $display("FAIL acc_second: result=%0d expected 30", res); end
    call(2'd3, 32'd0, 32'd7, res, e, lat);
    checks++;
    if (res !== 32'd30 || lat != 1) begin errors++; $display("FAIL read_swap: result=%0d lat=%0d expected 30/1", res, lat); end
    call(2'd2, 32'd1, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'd8) begin errors++; $display("FAIL acc_after_load: result=%0d expected 8", res); end
    call(2'd3, 32'd0, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'd8) begin errors++; $display("FAIL read_clear: result=%0d expected 8", res); end
  endtask

  task automatic test_reset_mid_mul;
    logic [31:0] res; logic e; int lat;
    call(2'd2, 32'd99, 32'd0, res, e, lat);
    start_call(2'd1, 32'd1234, 32'd5678);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL mid_reset_async: ack=%b busy=%b result=%h expected 0/0/0", ack, busy, result);
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL mid_reset_hold: ack=%b expected 0", ack); end
    rst_n = 1'b1;
    call(2'd3, 32'd0, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'd0) begin errors++; $display("FAIL mid_reset_acc: result=%0d expected 0", res); end
    call(2'd0, 32'd3, 32'd4, res, e, lat);
    checks++;
    if (res !== 32'd7) begin errors++; $display("FAIL mid_reset_add: result=%0d expected 7", res); end
  endtask

  task automatic test_req_drop;
    int lat; logic ok, ba;
    start_call(2'd1, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_ack(lat, ok, ba);
    checks++;
    if (!ok || result !== 32'd42) begin errors++; $display("FAIL drop_complete: ok=%b result=%0d expected 1/42", ok, result); end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_pulse: ack=%b busy=%b expected 0/0", ack, busy); end
  endtask

  task automatic test_back_to_back;
    int lat; logic ok, ba;
    start_call(2'd0, 32'd1, 32'd1);
    wait_ack(lat, ok, ba);
    arg0 = 32'd50; arg1 = 32'd60;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || result !== 32'd2) begin errors++; $display("FAIL b2b_hold: ack=%b result=%0d expected 1/2", ack, result); end
    req = 1'b0;
    @(negedge clk);
    start_call(2'd0, 32'd5, 32'd6);
    wait_ack(lat, ok, ba);
    checks++;
    if (!ok || lat != 1 || result !== 32'd11) begin
      errors++; $display("FAIL b2b_second: ok=%b lat=%0d result=%0d expected 1/1/11", ok, lat, result);
    end
    end_call();
  endtask

`ifdef RPC19_CALLCOUNT_EN
  task automatic test_callcount;
    logic [31:0] res; logic e; int lat;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (call_count !== 16'd0) begin errors++; $display("FAIL cc_reset: got %0d expected 0", call_count); end
    call(2'd0, 32'd1, 32'd2, res, e, lat);
    call(2'd0, 32'd3, 32'd4, res, e, lat);
    call(2'd2, 32'd42, 32'd0, res, e, lat);
    call(2'd1, 32'd2, 32'd3, res, e, lat);
    call(2'd0, 32'd5, 32'd6, res, e, lat);
    checks++;
    if (call_count !== 16'd5) begin errors++; $display("FAIL cc_five: got %0d expected 5", call_count); end
    call(2'd3, 32'd0, 32'h0000_FFFF, res, e, lat);
    checks++;
    if (res !== 32'd5) begin errors++; $display("FAIL cc_read: result=%0d expected 5", res); end
    checks++;
    if (call_count !== 16'd6) begin errors++; $display("FAIL cc_after: got %0d expected 6", call_count); end
    call(2'd3, 32'd0, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'd42) begin errors++; $display("FAIL cc_acc_kept: result=%0d expected 42", res); end
  endtask
`else
  task automatic test_read_ffff_plain;
    logic [31:0] res; logic e; int lat;
    call(2'd3, 32'd0, 32'h0000_FFFF, res, e, lat);
    checks++;
    if (res !== 32'd0) begin errors++; $display("FAIL plain_ffff_read: result=%0d expected 0", res); end
    call(2'd3, 32'd0, 32'd0, res, e, lat);
    checks++;
    if (res !== 32'h0000_FFFF) begin errors++; $display("FAIL plain_ffff_load: result=%h expected 0000ffff", res); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_acc();
    test_reset_mid_mul();
    test_req_drop();
    test_back_to_back();
`ifdef RPC19_CALLCOUNT_EN
    test_callcount();
`else
    test_read_ffff_plain();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
